// File: rtl/reduce_vector_unit.sv
// Multi-cycle vector reduction engine: folds up to N elements, LANES per cycle, into one scalar.
// Ops: wrapping/saturating sum, min, max, and, or, xor; signed or unsigned interpretation.
module reduce_vector_unit #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned LANES = 2,
    localparam int unsigned LW   = $clog2(N + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            start_i,
    input  logic [BITS-1:0] in_i [N],
    input  logic [LW-1:0]   in_len_i,
    input  logic [2:0]      sel_i,
    input  logic            is_signed_i,
    output logic [BITS-1:0] out_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            ovf_o,
    output logic            err_o
);

    localparam int unsigned AccW  = BITS + $clog2(N) + 1;
    localparam int unsigned IdxW  = LW + 1;
    localparam int unsigned AIdxW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OpSum = 3'b000;
    localparam logic [2:0] OpMax = 3'b001;
    localparam logic [2:0] OpMin = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpOr  = 3'b100;
    localparam logic [2:0] OpXor = 3'b101;
    localparam logic [2:0] OpSat = 3'b110;
    localparam logic [2:0] OpBad = 3'b111;

    localparam logic [BITS-1:0] SMaxB   = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] SMinB   = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] AllOnes = {BITS{1'b1}};

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    function automatic logic [AccW-1:0] ext(input logic [BITS-1:0] v, input logic sg);
        return sg ? {{(AccW-BITS){v[BITS-1]}}, v} : {{(AccW-BITS){1'b0}}, v};
    endfunction

    function automatic logic [AccW-1:0] identity(input logic [2:0] op, input logic sg);
        case (op)
            OpMax:   return sg ? ext(SMinB, 1'b1) : '0;
            OpMin:   return sg ? ext(SMaxB, 1'b1) : ext(AllOnes, 1'b0);
            OpAnd:   return '1;
            default: return '0;
        endcase
    endfunction

    state_e          state_q;
    logic [BITS-1:0] vec_q [N];
    logic [LW-1:0]   len_q;
    logic [2:0]      sel_q;
    logic            sgn_q;
    logic            bad_q;
    logic [AccW-1:0] acc_q, acc_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [BITS-1:0] out_q;
    logic            busy_q, done_q, ovf_q, err_q;

    logic [AccW-1:0] elem;
    logic [IdxW-1:0] pos;
    logic [AccW-1:0] hi_lim, lo_lim;
    logic            over, is_sum, bad_req;
    logic [BITS-1:0] res;

    // Lanes past the latched length are skipped, which equals folding in the identity.
    always_comb begin
        acc_d = acc_q;
        elem  = '0;
        pos   = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            pos  = idx_q + IdxW'(l);
            elem = ext(vec_q[pos[AIdxW-1:0]], sgn_q);
            if (pos < {1'b0, len_q}) begin
                case (sel_q)
                    OpSum, OpSat: acc_d = acc_d + elem;
                    OpMax:   if ($signed(elem) > $signed(acc_d)) acc_d = elem;
                    OpMin:   if ($signed(elem) < $signed(acc_d)) acc_d = elem;
                    OpAnd:   acc_d = acc_d & elem;
                    OpOr:    acc_d = acc_d | elem;
                    OpXor:   acc_d = acc_d ^ elem;
                    default: acc_d = acc_d;
                endcase
            end
        end
        idx_d = idx_q + IdxW'(LANES);
    end

    // The accumulator has headroom, so a signed compare is exact for zero-extended values too.
    always_comb begin
        hi_lim = sgn_q ? ext(SMaxB, 1'b1) : ext(AllOnes, 1'b0);
        lo_lim = sgn_q ? ext(SMinB, 1'b1) : '0;
        over   = ($signed(acc_q) > $signed(hi_lim)) || ($signed(acc_q) < $signed(lo_lim));
        is_sum = (sel_q == OpSum) || (sel_q == OpSat);
        res    = acc_q[BITS-1:0];
        if (sel_q == OpSat && over) begin
            res = acc_q[AccW-1] ? lo_lim[BITS-1:0] : hi_lim[BITS-1:0];
        end
        bad_req = (in_len_i == '0) || (in_len_i > LW'(N)) || (sel_i == OpBad);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(N); i++) vec_q[i] <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            sgn_q   <= 1'b0;
            bad_q   <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en_i) begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            vec_q  <= in_i;
                            len_q  <= in_len_i;
                            sel_q  <= sel_i;
                            sgn_q  <= is_signed_i;
                            busy_q <= 1'b1;
                            idx_q  <= '0;
                            acc_q  <= identity(sel_i, is_signed_i);
                            bad_q  <= bad_req;
                            state_q <= bad_req ? StFin : StRun;
                        end
                    end
                    StRun: begin
                        acc_q <= acc_d;
                        idx_q <= idx_d;
                        if (idx_d >= {1'b0, len_q}) state_q <= StFin;
                    end
                    StFin: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= bad_q ? '0 : res;
                        ovf_q   <= !bad_q && is_sum && over;
                        err_q   <= bad_q;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign ovf_o  = ovf_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_reduce_vector_unit.sv
// Randomised scoreboard bench for reduce_vector_unit against an arithmetic reference model.
module tb_reduce_vector_unit;

    typedef struct {
        logic [7:0] out;
        logic       ovf;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       start;
    logic [7:0] in_v [8];
    logic [3:0] in_len;
    logic [2:0] sel;
    logic       sgn;
    logic [7:0] out;
    logic       busy, done, ovf, err;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    reduce_vector_unit #(.BITS(8), .N(8), .LANES(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .start_i     (start),
        .in_i        (in_v),
        .in_len_i    (in_len),
        .sel_i       (sel),
        .is_signed_i (sgn),
        .out_o       (out),
        .busy_o      (busy),
        .done_o      (done),
        .ovf_o       (ovf),
        .err_o       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer fold over the first len elements.
    function automatic exp_t model(input logic [7:0] v [8], input int len,
                                   input logic [2:0] op, input bit sg);
        exp_t e;
        int   lo, hi, acc, x;
        e.out = 8'h00; e.ovf = 1'b0; e.err = 1'b0; e.cyc = 0;
        if (len < 1 || len > 8 || op == 3'b111) begin
            e.err = 1'b1;
            return e;
        end
        lo  = sg ? -128 : 0;
        hi  = sg ? 127 : 255;
        acc = 0;
        for (int i = 0; i < len; i++) begin
            x = int'(v[i]);
            if (sg && x > 127) x -= 256;
            case (op)
                3'd0, 3'd6: acc = (i == 0) ? x : acc + x;
                3'd1:       acc = (i == 0 || x > acc) ? x : acc;
                3'd2:       acc = (i == 0 || x < acc) ? x : acc;
                3'd3:       acc = (i == 0) ? x : (acc & x);
                3'd4:       acc = (i == 0) ? x : (acc | x);
                default:    acc = (i == 0) ? x : (acc ^ x);
            endcase
        end
        e.out = acc[7:0];
        if (op == 3'd0 || op == 3'd6) begin
            e.ovf = (acc < lo) || (acc > hi);
            if (op == 3'd6 && e.ovf) e.out = (acc < lo) ? lo[7:0] : hi[7:0];
        end
        return e;
    endfunction

    task automatic scramble();
        for (int i = 0; i < 8; i++) in_v[i] = 8'($urandom);
        in_len = 4'($urandom);
        sel    = 3'($urandom);
        sgn    = 1'($urandom);
    endtask

    task automatic run_op(input logic [7:0] v [8], input int len, input logic [2:0] op,
                          input bit sg, input int stall, input bit poke);
        exp_t e;
        int   t;
        int   lat;
        t = 0;
        while (busy === 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("idle_timeout", t, 0);
        in_v   = v;
        in_len = 4'(len);
        sel    = op;
        sgn    = sg;
        start  = 1'b1;
        e      = model(v, len, op, sg);
        lat    = e.err ? 1 : (len + 1) / 2 + 1;
        e.cyc  = cyc + lat + 1 + stall;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        scramble();
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (stall > 0) begin
            @(negedge clk);
            en = 1'b0;
            repeat (stall) @(negedge clk);
            en = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out", int'(out), int'(mon_e.out));
                    chk("ovf", int'(ovf), int'(mon_e.ovf));
                    chk("err", int'(err), int'(mon_e.err));
                    chk("done_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        logic [7:0] v [8];
        int         len, stall, t;
        logic [2:0] op;
        bit         sg, poke;

        rst_n = 1'b0; en = 1'b1; start = 1'b0; in_len = '0; sel = '0; sgn = 1'b0;
        for (int i = 0; i < 8; i++) in_v[i] = 8'h00;
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        v = '{8'h04, 8'h40, 8'h12, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_op(v, 4, 3'd1, 1'b0, 0, 0);
        run_op(v, 4, 3'd5, 1'b0, 0, 0);
        run_op(v, 4, 3'd0, 1'b0, 0, 0);
        v = '{8'h80, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_op(v, 2, 3'd0, 1'b0, 0, 0);
        run_op(v, 2, 3'd6, 1'b0, 0, 0);
        v = '{8'h70, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_op(v, 2, 3'd6, 1'b1, 0, 0);
        v = '{8'hF0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_op(v, 2, 3'd0, 1'b1, 0, 0);
        v = '{8'h03, 8'hF0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_op(v, 3, 3'd2, 1'b1, 0, 0);
        run_op(v, 3, 3'd2, 1'b0, 0, 0);
        run_op(v, 0, 3'd0, 1'b0, 0, 0);
        run_op(v, 9, 3'd0, 1'b0, 0, 0);
        run_op(v, 3, 3'd7, 1'b0, 0, 0);
        v = '{8'h11, 8'h7F, 8'h22, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_op(v, 4, 3'd1, 1'b0, 0, 1);
        run_op(v, 4, 3'd0, 1'b0, 3, 0);

        // Abort mid-run: outputs clear at once and the aborted op never completes.
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_op(v, 8, 3'd0, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("abort_out", int'(out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_err", int'(err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(v, 8, 3'd0, 1'b0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9)
                                              : int'($urandom_range(1, 8));
            op    = 3'($urandom_range(0, 7));
            sg    = 1'($urandom);
            stall = (len >= 3 && len <= 8 && op != 3'd7 && $urandom_range(0, 4) == 0)
                    ? int'($urandom_range(1, 3)) : 0;
            poke  = (stall == 0) && ($urandom_range(0, 3) == 0);
            run_op(v, len, op, sg, stall, poke);
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain", sb.size(), 0);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
